// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: data word, ALU opcode,
// arbiter FSM state, requester count and a saturating counter helper.
package alu_share_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_NREQ = 2;

    // 16-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus between the two requesters, the arbiter and the shared ALU.
// master: requester side, slave: arbiter, alu: the ALU instance.
interface alu_share_arbiter_if;
    import alu_share_arbiter_pkg::*;

    logic [ARB_NREQ-1:0] req;
    logic [ARB_NREQ-1:0] lock;
    word_t               a0;
    word_t               b0;
    word_t               a1;
    word_t               b1;
    aluop_t              op0;
    aluop_t              op1;
    logic [ARB_NREQ-1:0] gnt;
    logic [ARB_NREQ-1:0] rvalid;
    word_t               res_out;
    logic                res_N;
    logic                res_V;
    logic                res_Z;
    word_t               alu_a;
    word_t               alu_b;
    aluop_t              alu_op;
    word_t               alu_out;
    logic                alu_N;
    logic                alu_V;
    logic                alu_Z;

    modport master (
        output req, lock, a0, b0, a1, b1, op0, op1,
        input  gnt, rvalid, res_out, res_N, res_V, res_Z
    );

    modport slave (
        input  req, lock, a0, b0, a1, b1, op0, op1,
        output gnt, rvalid, res_out, res_N, res_V, res_Z,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_N, alu_V, alu_Z
    );

    modport alu (
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_N, alu_V, alu_Z
    );

endinterface

// File: rtl/alu_share_arbiter_pick.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// two requests are resolved in favour of the pointer.
module alu_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    // one-hot winner selection from request vector and rr pointer
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ptr ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between requester 0 (execute stage) and requester 1
// (multi-cycle helper). Round-robin with short lock bursts, combinational
// grant, one-cycle registered result return.
// Optional build macro ALU_ARB_STATS_EN adds grant/stall statistics outputs.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_INIT = 0,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]          gnt0_cnt,
    output logic [15:0]          gnt1_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int unsigned    BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]  BURST_ONE = BW'(1'b1);
    localparam logic [BW-1:0]  BURST_ZERO = BW'(1'b0);

    arb_state_t    state_r, state_nxt_s;
    logic [BW-1:0] burst_r, burst_nxt_s;
    logic          ptr_r, ptr_nxt_s;
    logic [1:0]    pick_s, gnt_s;
    logic          own_s, oth_s;
    logic [1:0]    rvalid_r;
    word_t         res_out_r;
    logic          res_n_r, res_v_r, res_z_r;

    alu_arb_pick u_pick (
        .req  (bus.req),
        .ptr  (ptr_r),
        .pick (pick_s)
    );

    // FSM, burst counter and round-robin pointer state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            burst_r <= BURST_ZERO;
            ptr_r   <= 1'(PRIO_INIT);
        end else begin
            state_r <= state_nxt_s;
            burst_r <= burst_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // grant decision and next state; a locked owner keeps the ALU until its
    // burst is spent while the other side waits
    always_comb begin
        gnt_s       = 2'b00;
        state_nxt_s = state_r;
        burst_nxt_s = burst_r;
        own_s       = (state_r == OWN1) ? 1'b1 : 1'b0;
        oth_s       = ~own_s;
        case (state_r)
            IDLE: begin
                gnt_s = pick_s;
                if (pick_s[0] && bus.lock[0]) begin
                    state_nxt_s = OWN0;
                    burst_nxt_s = BURST_ONE;
                end else if (pick_s[1] && bus.lock[1]) begin
                    state_nxt_s = OWN1;
                    burst_nxt_s = BURST_ONE;
                end else begin
                    state_nxt_s = IDLE;
                    burst_nxt_s = BURST_ZERO;
                end
            end
            OWN0, OWN1: begin
                if (bus.req[own_s] && (!bus.req[oth_s] || (burst_r < BURST_MAX))) begin
                    gnt_s[own_s] = 1'b1;
                    if (bus.lock[own_s]) begin
                        burst_nxt_s = (burst_r < BURST_MAX) ? (burst_r + BURST_ONE) : burst_r;
                    end else begin
                        state_nxt_s = IDLE;
                        burst_nxt_s = BURST_ZERO;
                    end
                end else if (!bus.req[own_s]) begin
                    // owner let go: hand straight to the other side, no bubble
                    gnt_s[oth_s] = bus.req[oth_s];
                    state_nxt_s  = IDLE;
                    burst_nxt_s  = BURST_ZERO;
                end else begin
                    // burst exhausted with the other side waiting
                    gnt_s[oth_s] = 1'b1;
                    if (bus.lock[oth_s]) begin
                        state_nxt_s = oth_s ? OWN1 : OWN0;
                        burst_nxt_s = BURST_ONE;
                    end else begin
                        state_nxt_s = IDLE;
                        burst_nxt_s = BURST_ZERO;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                burst_nxt_s = BURST_ZERO;
            end
        endcase
        if (gnt_s[0]) begin
            ptr_nxt_s = 1'b1;
        end else if (gnt_s[1]) begin
            ptr_nxt_s = 1'b0;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // grant output and ALU operand mux; idle ALU sees a harmless shift
    always_comb begin
        bus.gnt = gnt_s;
        if (gnt_s[1]) begin
            bus.alu_a  = bus.a1;
            bus.alu_b  = bus.b1;
            bus.alu_op = bus.op1;
        end else if (gnt_s[0]) begin
            bus.alu_a  = bus.a0;
            bus.alu_b  = bus.b0;
            bus.alu_op = bus.op0;
        end else begin
            bus.alu_a  = bus.a0;
            bus.alu_b  = bus.b0;
            bus.alu_op = ALU_SLL;
        end
    end

    // capture the granted op's result and flags; rvalid pulses for one cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rvalid_r  <= 2'b00;
            res_out_r <= 32'd0;
            res_n_r   <= 1'b0;
            res_v_r   <= 1'b0;
            res_z_r   <= 1'b0;
        end else begin
            rvalid_r <= gnt_s;
            if (gnt_s != 2'b00) begin
                res_out_r <= bus.alu_out;
                res_n_r   <= bus.alu_N;
                res_v_r   <= bus.alu_V;
                res_z_r   <= bus.alu_Z;
            end else begin
                res_out_r <= res_out_r;
                res_n_r   <= res_n_r;
                res_v_r   <= res_v_r;
                res_z_r   <= res_z_r;
            end
        end
    end

    assign bus.rvalid  = rvalid_r;
    assign bus.res_out = res_out_r;
    assign bus.res_N   = res_n_r;
    assign bus.res_V   = res_v_r;
    assign bus.res_Z   = res_z_r;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt0_cnt_r, gnt1_cnt_r, stall_cnt_r;

    // saturating grant and stall statistics
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gnt0_cnt_r  <= 16'd0;
            gnt1_cnt_r  <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            gnt0_cnt_r  <= gnt_s[0] ? sat_inc16(gnt0_cnt_r) : gnt0_cnt_r;
            gnt1_cnt_r  <= gnt_s[1] ? sat_inc16(gnt1_cnt_r) : gnt1_cnt_r;
            stall_cnt_r <= ((bus.req & ~gnt_s) != 2'b00) ? sat_inc16(stall_cnt_r) : stall_cnt_r;
        end
    end

    assign gnt0_cnt  = gnt0_cnt_r;
    assign gnt1_cnt  = gnt1_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by
// randomized traffic checked against a behavioural arbitration model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int MAXB = 4;

    logic clk;
    logic nrst;
    int   n_vec;
    int   n_err;

    alu_share_arbiter_if bus();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

    alu_share_arbiter #(.PRIO_INIT(0), .MAX_BURST(MAXB)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt0_cnt  (gnt0_cnt),
        .gnt1_cnt  (gnt1_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU: returns {N, V, Z, out}
    function automatic logic [34:0] alu_calc(input aluop_t op, input word_t a, input word_t b);
        word_t r;
        logic  v;
        v = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = word_t'($signed(a) >>> b[4:0]);
            ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default:  r = 32'd0;
        endcase
        return {r[31], v, (r == 32'd0), r};
    endfunction

    always_comb begin
        {bus.alu_N, bus.alu_V, bus.alu_Z, bus.alu_out} = alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    task automatic idle_inputs();
        bus.req  = 2'b00;
        bus.lock = 2'b00;
        bus.a0 = 32'd0; bus.b0 = 32'd0; bus.op0 = ALU_SLL;
        bus.a1 = 32'd0; bus.b1 = 32'd0; bus.op1 = ALU_SLL;
    endtask

    // reset pulse; leaves the bench 1 time unit after a rising edge
    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt got=%b want=00", bus.gnt);
        end
        n_vec++;
        if (bus.rvalid !== 2'b00) begin
            n_err++; $display("FAIL reset_rvalid got=%b want=00", bus.rvalid);
        end
        n_vec++;
        if ({bus.res_N, bus.res_V, bus.res_Z, bus.res_out} !== 35'd0) begin
            n_err++; $display("FAIL reset_res got=%h nvz=%b%b%b want=0", bus.res_out, bus.res_N, bus.res_V, bus.res_Z);
        end
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_contended();
        do_reset();
        bus.req = 2'b11;
        bus.a0 = 32'd3; bus.b0 = 32'd4; bus.op0 = ALU_ADD;
        bus.a1 = 32'd9; bus.b1 = 32'd2; bus.op1 = ALU_SUB;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b01) begin
            n_err++; $display("FAIL contend_gnt0 got=%b want=01", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req = 2'b10;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b10) begin
            n_err++; $display("FAIL contend_gnt1 got=%b want=10", bus.gnt);
        end
        n_vec++;
        if (bus.rvalid !== 2'b01 || bus.res_out !== 32'd7) begin
            n_err++; $display("FAIL contend_res0 got rv=%b res=%0d want rv=01 res=7", bus.rvalid, bus.res_out);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        @(negedge clk);
        n_vec++;
        if (bus.rvalid !== 2'b10 || bus.res_out !== 32'd7) begin
            n_err++; $display("FAIL contend_res1 got rv=%b res=%0d want rv=10 res=7", bus.rvalid, bus.res_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_zero();
        do_reset();
        bus.req = 2'b10;
        bus.a1 = 32'd0; bus.b1 = 32'd0; bus.op1 = ALU_SUB;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b10) begin
            n_err++; $display("FAIL single_gnt got=%b want=10", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        @(negedge clk);
        n_vec++;
        if (bus.rvalid !== 2'b10 || bus.res_out !== 32'd0 || bus.res_Z !== 1'b1) begin
            n_err++; $display("FAIL single_res got rv=%b res=%0d Z=%b want rv=10 res=0 Z=1", bus.rvalid, bus.res_out, bus.res_Z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        logic [1:0] want;
        do_reset();
        bus.req  = 2'b11;
        bus.lock = 2'b01;
        bus.a0 = 32'd1; bus.b0 = 32'd1; bus.op0 = ALU_ADD;
        bus.a1 = 32'd5; bus.b1 = 32'd1; bus.op1 = ALU_SUB;
        for (int c = 1; c <= MAXB + 1; c++) begin
            want = (c <= MAXB) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_vec++;
            if (bus.gnt !== want) begin
                n_err++; $display("FAIL burst_c%0d got=%b want=%b", c, bus.gnt, want);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req  = 2'b01;
        bus.lock = 2'b01;
        bus.a0 = 32'd10; bus.b0 = 32'd20; bus.op0 = ALU_ADD;
        bus.a1 = 32'hF0; bus.b1 = 32'h0F; bus.op1 = ALU_OR;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b01) begin
            n_err++; $display("FAIL drop_own got=%b want=01", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req = 2'b10;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b10 || bus.rvalid !== 2'b01 || bus.res_out !== 32'd30) begin
            n_err++; $display("FAIL drop_handoff got gnt=%b rv=%b res=%0d want gnt=10 rv=01 res=30", bus.gnt, bus.rvalid, bus.res_out);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        @(negedge clk);
        n_vec++;
        if (bus.rvalid !== 2'b10 || bus.res_out !== 32'hFF) begin
            n_err++; $display("FAIL drop_res1 got rv=%b res=%h want rv=10 res=ff", bus.rvalid, bus.res_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.req = 2'b01;
        bus.a0 = 32'h7FFFFFFF; bus.b0 = 32'd1; bus.op0 = ALU_ADD;
        @(negedge clk);
        n_vec++;
        if (bus.gnt !== 2'b01) begin
            n_err++; $display("FAIL midrst_gnt got=%b want=01", bus.gnt);
        end
        nrst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.rvalid !== 2'b00 || {bus.res_N, bus.res_V, bus.res_Z, bus.res_out} !== 35'd0) begin
            n_err++; $display("FAIL midrst_res got rv=%b res=%h nvz=%b%b%b want rv=00 res=0 nvz=000",
                              bus.rvalid, bus.res_out, bus.res_N, bus.res_V, bus.res_Z);
        end
        idle_inputs();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int ncyc);
        word_t       da[2], db[2];
        aluop_t      dop[2];
        logic        pend[2];
        int          m_owner, m_streak, m_rr, w, o, t;
        logic [1:0]  r, l, exp_gnt, exp_rv;
        logic [34:0] exp_res;
        do_reset();
        m_owner = -1; m_streak = 0; m_rr = 0;
        exp_rv = 2'b00; exp_res = 35'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    da[i]  = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : word_t'($urandom());
                    db[i]  = ($urandom_range(0, 7) == 0) ? 32'd1 : word_t'($urandom());
                    dop[i] = aluop_t'($urandom_range(0, 10));
                end
            end
            bus.req  = {pend[1], pend[0]};
            bus.lock = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bus.a0 = da[0]; bus.b0 = db[0]; bus.op0 = dop[0];
            bus.a1 = da[1]; bus.b1 = db[1]; bus.op1 = dop[1];
            @(negedge clk);
            n_vec++;
            if (bus.rvalid !== exp_rv) begin
                n_err++; $display("FAIL rand_rvalid c=%0d got=%b want=%b", c, bus.rvalid, exp_rv);
            end
            n_vec++;
            if ({bus.res_N, bus.res_V, bus.res_Z, bus.res_out} !== exp_res) begin
                n_err++; $display("FAIL rand_res c=%0d got=%h nvz=%b%b%b want=%h nvz=%b",
                                  c, bus.res_out, bus.res_N, bus.res_V, bus.res_Z, exp_res[31:0], exp_res[34:32]);
            end
            r = bus.req; l = bus.lock;
            if (m_owner < 0) begin
                if (r == 2'b11)  w = m_rr;
                else if (r[0])   w = 0;
                else if (r[1])   w = 1;
                else             w = -1;
            end else begin
                o = m_owner; t = 1 - o;
                if (r[o] && (!r[t] || m_streak < MAXB)) w = o;
                else if (r[t])                          w = t;
                else                                    w = -1;
            end
            exp_gnt = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
            n_vec++;
            if (bus.gnt !== exp_gnt) begin
                n_err++; $display("FAIL rand_gnt c=%0d got=%b want=%b owner=%0d streak=%0d", c, bus.gnt, exp_gnt, m_owner, m_streak);
            end
            if (w >= 0) begin
                n_vec++;
                if (bus.alu_op !== dop[w] || bus.alu_a !== da[w] || bus.alu_b !== db[w]) begin
                    n_err++; $display("FAIL rand_mux c=%0d got op=%0d a=%h b=%h want op=%0d a=%h b=%h",
                                      c, bus.alu_op, bus.alu_a, bus.alu_b, dop[w], da[w], db[w]);
                end
            end
            if (m_owner >= 0 && w == m_owner) begin
                m_streak = (m_streak + 1 > MAXB) ? MAXB : m_streak + 1;
                if (!l[w]) begin m_owner = -1; m_streak = 0; end
            end else if (m_owner >= 0 && !r[m_owner]) begin
                m_owner = -1; m_streak = 0;
            end else if (w >= 0) begin
                m_owner  = l[w] ? w : -1;
                m_streak = l[w] ? 1 : 0;
            end
            exp_rv = exp_gnt;
            if (w >= 0) begin
                m_rr    = 1 - w;
                exp_res = alu_calc(dop[w], da[w], db[w]);
                pend[w] = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        logic [16:0] sum;
        do_reset();
        bus.req = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        sum = {1'b0, gnt0_cnt} + {1'b0, gnt1_cnt};
        n_vec++;
        if (stall_cnt !== 16'd3 || sum !== 17'd3) begin
            n_err++; $display("FAIL stats_3 got stall=%0d gsum=%0d want stall=3 gsum=3", stall_cnt, sum);
        end
        repeat (65540) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL stats_sat got stall=%h want=ffff", stall_cnt);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        nrst  = 1'b0;
        idle_inputs();
        test_reset();
        test_contended();
        test_single_zero();
        test_burst();
        test_owner_drop();
        test_reset_mid_op();
        test_random(3000);
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
